byte_striping: RTL and testbench

- Upstream neighbour of byte_unstriping: splits one 32-bit word stream into two 32-bit lanes, lane_0 and lane_1.
- Consecutive valid words are paired: the first goes to lane_0 and the second to lane_1. Both lanes update together so the unstriping stage receives aligned lanes.
- Runs on the fast clock only (clk_2f). Lane outputs are held for two cycles, i.e. one clk_f period, so a half-rate consumer samples each pair exactly once.
- An incomplete pair is flushed after a programmable idle timeout.

---
 rtl/striping_pkg.sv | 21 ++
 rtl/byte_striping_if.sv | 29 ++
 rtl/stripe_hold_timer.sv | 57 +++++
 rtl/byte_striping.sv | 152 +++++++++++++++
 tb/tb_byte_striping.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/striping_pkg.sv
// Shared types and defaults for the byte striping / unstriping pair.
package striping_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_e;

    localparam int          DATA_W_DEF    = 32;
    localparam logic [31:0] IDLE_WORD_DEF = 32'h0000_0000;

    // Lanes stay valid this many fast cycles, i.e. one half-rate period.
    localparam int HOLD_CYCLES = 2;

    // Idle timer width. It must reach TIMEOUT-1, and it keeps at least one bit
    // so that a disabled timeout (TIMEOUT=0) still yields a legal vector.
    function automatic int timer_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/byte_striping_if.sv
// Word-in / paired-lanes-out bus of byte_striping.
interface byte_striping_if
    import striping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] lane_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_0;
    logic              valid_1;
    logic              pair_stb;
    logic              pending;

    // Word producer / lane consumer side.
    modport master (
        output valid_in, data_in,
        input  lane_0, lane_1, valid_0, valid_1, pair_stb, pending
    );

    // Striping block side.
    modport slave (
        input  valid_in, data_in,
        output lane_0, lane_1, valid_0, valid_1, pair_stb, pending
    );

endinterface

// File: rtl/stripe_hold_timer.sv
// Counters for byte_striping: the lane valid-hold window and the HALF-state
// idle timeout that triggers flushing a lone lane_0 word.
module stripe_hold_timer
    import striping_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_half,
    input  logic valid_in,
    input  logic load_timer,
    input  logic emit,
    output logic flush_now,
    output logic hold_expired
);

    localparam int            TW         = timer_w(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    hold_cnt_q, hold_cnt_d;

    // NOTE: every output is given a default before any branch, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        flush_now    = (TIMEOUT != 0) && in_half && !valid_in && (timer_q == TIMER_LAST);
        hold_expired = (hold_cnt_q == 2'd1) && !emit;

        timer_d = timer_q;
        if (load_timer || emit) begin
            timer_d = '0;
        end else if (in_half && !valid_in && (TIMEOUT != 0)) begin
            timer_d = timer_q + TW'(1);
        end

        hold_cnt_d = hold_cnt_q;
        if (emit) begin
            hold_cnt_d = 2'(HOLD_CYCLES);
        end else if (hold_cnt_q != 2'd0) begin
            hold_cnt_d = hold_cnt_q - 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            timer_q    <= timer_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/byte_striping.sv
// Pairs consecutive valid words onto lane_0/lane_1 on clk_2f, holding each pair
// for one half-rate period. Optional pair counter: BYTE_STRIPING_PAIR_CNT_EN.
module byte_striping
    import striping_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                TIMEOUT   = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_WORD_DEF)
`ifdef BYTE_STRIPING_PAIR_CNT_EN
    ,
    parameter int                CNT_W     = 16
`endif
) (
    input  logic                 clk_2f,
    input  logic                 reset_L,
    byte_striping_if.slave       bus
`ifdef BYTE_STRIPING_PAIR_CNT_EN
    ,
    output logic [CNT_W-1:0]     pair_count
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_0_q, hold_0_d;
    logic [DATA_W-1:0] lane_0_q, lane_0_d;
    logic [DATA_W-1:0] lane_1_q, lane_1_d;
    logic              valid_0_q, valid_0_d;
    logic              valid_1_q, valid_1_d;
    logic              pair_stb_q, pair_stb_d;
    logic              pending_q, pending_d;

    logic              emit;
    logic              load_timer;
    logic              flush_now;
    logic              hold_expired;

    stripe_hold_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_hold_timer (
        .clk          (clk_2f),
        .rst_n        (reset_L),
        .in_half      (state_q == HALF),
        .valid_in     (bus.valid_in),
        .load_timer   (load_timer),
        .emit         (emit),
        .flush_now    (flush_now),
        .hold_expired (hold_expired)
    );

    always_comb begin
        state_d    = state_q;
        hold_0_d   = hold_0_q;
        lane_0_d   = lane_0_q;
        lane_1_d   = lane_1_q;
        valid_0_d  = valid_0_q;
        valid_1_d  = valid_1_q;
        pair_stb_d = 1'b0;
        emit       = 1'b0;
        load_timer = 1'b0;

        // Lane data keeps its last value once the hold window lapses.
        if (hold_expired) begin
            valid_0_d = 1'b0;
            valid_1_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    hold_0_d   = bus.data_in;
                    load_timer = 1'b1;
                    state_d    = HALF;
                end
            end
            HALF: begin
                // A second word beats a coincident timeout.
                if (bus.valid_in) begin
                    lane_0_d   = hold_0_q;
                    lane_1_d   = bus.data_in;
                    valid_0_d  = 1'b1;
                    valid_1_d  = 1'b1;
                    pair_stb_d = 1'b1;
                    emit       = 1'b1;
                    state_d    = IDLE;
                end else if (flush_now) begin
                    lane_0_d   = hold_0_q;
                    lane_1_d   = IDLE_WORD;
                    valid_0_d  = 1'b1;
                    valid_1_d  = 1'b0;
                    pair_stb_d = 1'b1;
                    emit       = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (state_d == HALF);
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            hold_0_q   <= '0;
            lane_0_q   <= '0;
            lane_1_q   <= '0;
            valid_0_q  <= 1'b0;
            valid_1_q  <= 1'b0;
            pair_stb_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_0_q   <= hold_0_d;
            lane_0_q   <= lane_0_d;
            lane_1_q   <= lane_1_d;
            valid_0_q  <= valid_0_d;
            valid_1_q  <= valid_1_d;
            pair_stb_q <= pair_stb_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.lane_0   = lane_0_q;
    assign bus.lane_1   = lane_1_q;
    assign bus.valid_0  = valid_0_q;
    assign bus.valid_1  = valid_1_q;
    assign bus.pair_stb = pair_stb_q;
    assign bus.pending  = pending_q;

`ifdef BYTE_STRIPING_PAIR_CNT_EN
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    // Counts full pairs and flushes alike; wraps naturally.
    always_comb begin
        pair_count_d = pair_count_q;
        if (emit) begin
            pair_count_d = pair_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            pair_count_q <= '0;
        end else begin
            pair_count_q <= pair_count_d;
        end
    end

    assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_byte_striping.sv
// Self-checking bench for byte_striping: directed scenarios with literal
// expectations plus randomized traffic compared against a pairing model.
module tb_byte_striping;

    localparam int          TB_TIMEOUT = 4;
    localparam logic [31:0] TB_IDLE    = 32'h0000_0000;
    localparam int          AGE_NONE   = 1000;

    logic clk_2f;
    logic reset_L;

    byte_striping_if #(.DATA_W(32)) bus ();

`ifdef BYTE_STRIPING_PAIR_CNT_EN
    logic [15:0] pair_count;
`endif

    byte_striping #(
        .DATA_W    (32),
        .TIMEOUT   (TB_TIMEOUT),
        .IDLE_WORD (TB_IDLE)
    ) dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus)
`ifdef BYTE_STRIPING_PAIR_CNT_EN
        ,
        .pair_count (pair_count)
`endif
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    int n_vec  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word either waits alone for a partner or is paired;
    // outputs are derived from the last emitted pair and its age in cycles.
    bit          m_have;
    logic [31:0] m_first;
    int          m_idle;
    logic [31:0] m_l0, m_l1;
    bit          m_pair_full;
    int          m_age;
    int          m_cnt;

    always @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            m_have      <= 1'b0;
            m_first     <= '0;
            m_idle      <= 0;
            m_l0        <= '0;
            m_l1        <= '0;
            m_pair_full <= 1'b0;
            m_age       <= AGE_NONE;
            m_cnt       <= 0;
        end else if (m_have && bus.valid_in) begin
            m_l0        <= m_first;
            m_l1        <= bus.data_in;
            m_pair_full <= 1'b1;
            m_age       <= 0;
            m_have      <= 1'b0;
            m_cnt       <= m_cnt + 1;
        end else if (m_have && TB_TIMEOUT != 0 && m_idle == TB_TIMEOUT - 1) begin
            m_l0        <= m_first;
            m_l1        <= TB_IDLE;
            m_pair_full <= 1'b0;
            m_age       <= 0;
            m_have      <= 1'b0;
            m_cnt       <= m_cnt + 1;
        end else begin
            if (m_age < AGE_NONE) m_age <= m_age + 1;
            if (m_have) begin
                m_idle <= m_idle + 1;
            end else if (bus.valid_in) begin
                m_have  <= 1'b1;
                m_first <= bus.data_in;
                m_idle  <= 0;
            end
        end
    end

    always @(negedge clk_2f) begin
        if (cmp_en) begin
            check("lane_0",   64'(bus.lane_0),   64'(m_l0));
            check("lane_1",   64'(bus.lane_1),   64'(m_l1));
            check("valid_0",  64'(bus.valid_0),  64'(m_age < 2));
            check("valid_1",  64'(bus.valid_1),  64'(m_pair_full && m_age < 2));
            check("pair_stb", 64'(bus.pair_stb), 64'(m_age == 0));
            check("pending",  64'(bus.pending),  64'(m_have));
`ifdef BYTE_STRIPING_PAIR_CNT_EN
            check("pair_count", 64'(pair_count), 64'(m_cnt[15:0]));
`endif
        end
    end

    task automatic drive(input bit v, input logic [31:0] d);
        @(posedge clk_2f);
        #1;
        bus.valid_in = v;
        bus.data_in  = d;
    endtask

    task automatic check_out(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                             input bit v0, input bit v1, input bit stb, input bit pend);
        check({tag, ".lane_0"},   64'(bus.lane_0),   64'(l0));
        check({tag, ".lane_1"},   64'(bus.lane_1),   64'(l1));
        check({tag, ".valid_0"},  64'(bus.valid_0),  64'(v0));
        check({tag, ".valid_1"},  64'(bus.valid_1),  64'(v1));
        check({tag, ".pair_stb"}, 64'(bus.pair_stb), 64'(stb));
        check({tag, ".pending"},  64'(bus.pending),  64'(pend));
    endtask

    initial begin
        int pcts[4];
        pcts = '{90, 50, 20, 5};

        // Reset with live-looking input: nothing may leak through.
        reset_L      = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = $urandom;
        repeat (3) begin
            @(posedge clk_2f);
            #1 bus.data_in = $urandom;
        end
        check_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BYTE_STRIPING_PAIR_CNT_EN
        check("reset.pair_count", 64'(pair_count), 64'd0);
`endif
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        @(negedge clk_2f);
        #1 reset_L = 1'b1;
        cmp_en = 1'b1;

        // Back-to-back pairs.
        drive(1'b1, 32'hFFFF_FFFF);
        drive(1'b1, 32'hEEEE_EEEE);
        drive(1'b1, 32'hDDDD_DDDD);
        check_out("b2b.first", 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'hCCCC_CCCC);
        check_out("b2b.gap", 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0);
        check_out("b2b.second", 32'hDDDD_DDDD, 32'hCCCC_CCCC, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 32'h0);

        // Flush of a lone word after TIMEOUT idle cycles.
        drive(1'b1, 32'hBBBB_BBBB);
        drive(1'b0, 32'h0);
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            check("flush.pending_hi", 64'(bus.pending), 64'd1);
            @(posedge clk_2f);
            #1;
        end
        check_out("flush", 32'hBBBB_BBBB, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 32'h0);

        // Second word lands on the timeout cycle: full pair wins.
        drive(1'b1, 32'h1234_5678);
        repeat (3) drive(1'b0, 32'h0);
        drive(1'b1, 32'hAAAA_AAAA);
        drive(1'b0, 32'h0);
        check_out("race", 32'h1234_5678, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 32'h0);

        // Hold expiry: valids drop two cycles after pair_stb, data holds.
        drive(1'b1, 32'h1111_1111);
        drive(1'b1, 32'h2222_2222);
        drive(1'b0, 32'h0);
        check_out("hold.t0", 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk_2f);
        #1;
        check_out("hold.t1", 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk_2f);
        #1;
        check_out("hold.t2", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a pair is half built.
        drive(1'b1, 32'h7777_7777);
        drive(1'b0, 32'h0);
        check("areset.pending_before", 64'(bus.pending), 64'd1);
        #2 reset_L = 1'b0;
        #1;
        check("areset.pending_now", 64'(bus.pending), 64'd0);
        check("areset.lane_0", 64'(bus.lane_0), 64'd0);
`ifdef BYTE_STRIPING_PAIR_CNT_EN
        check("areset.pair_count", 64'(pair_count), 64'd0);
`endif
        @(negedge clk_2f);
        #1 reset_L = 1'b1;
        drive(1'b1, 32'h8888_8888);
        drive(1'b1, 32'h9999_9999);
        drive(1'b0, 32'h0);
        check_out("areset.next", 32'h8888_8888, 32'h9999_9999, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef BYTE_STRIPING_PAIR_CNT_EN
        check("areset.next_count", 64'(pair_count), 64'd1);
`endif

        // Randomized traffic at several densities, checked by the model.
        for (int blk = 0; blk < 12; blk++) begin
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 99) < pcts[blk % 4], $urandom);
            end
        end
        drive(1'b0, 32'h0);
        repeat (8) @(posedge clk_2f);
        @(negedge clk_2f);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
